// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - state encoding and default timing for the button step conditioner
package btn_cond_pkg;

    localparam int STATE_W = 3;

    localparam int DEFAULT_DB_CYCLES     = 4;
    localparam int DEFAULT_HOLD_CYCLES   = 8;
    localparam int DEFAULT_REPEAT_CYCLES = 3;
    localparam int DEFAULT_CNT_W         = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } btn_state_e;

endpackage

// File: rtl/btn_step_conditioner_if.sv
// rtl/btn_step_conditioner_if.sv - button input and step output bundle
interface btn_step_conditioner_if;

    logic btn_raw;
    logic rpt_en;
    logic step;
    logic btn_level;
    logic rpt_active;

    modport master (
        output btn_raw,
        output rpt_en,
        input  step,
        input  btn_level,
        input  rpt_active
    );

    modport slave (
        input  btn_raw,
        input  rpt_en,
        output step,
        output btn_level,
        output rpt_active
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_step_conditioner.sv
// rtl/btn_step_conditioner.sv - debounces a raw button into single-cycle step pulses with auto-repeat
module btn_step_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    btn_step_conditioner_if.slave   bus
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             step_q, step_d;
    logic             level_q, level_d;
    logic             rpt_q, rpt_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (bus.btn_raw),
        .q_o   (btn_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
            level_q <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            level_q <= level_d;
            rpt_q   <= rpt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + CNT_W'(1);
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (btn_s) state_d = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (timer_q == DB_LAST) begin
                    state_d = ST_HELD;
                    step_d  = 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                end else if (!bus.rpt_en) begin
                    // Hold-off only accumulates while repeat is allowed.
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    step_d  = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                end else if (!bus.rpt_en) begin
                    state_d = ST_HELD;
                end else if (timer_q == REP_LAST) begin
                    step_d  = 1'b1;
                    timer_d = '0;
                end
            end
            ST_RELEASE_DB: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                end else if (timer_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (state_d != state_q) timer_d = '0;

        level_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) || (state_d == ST_RELEASE_DB);
        rpt_d   = (state_d == ST_REPEAT);
    end

    assign bus.step       = step_q;
    assign bus.btn_level  = level_q;
    assign bus.rpt_active = rpt_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// tb/tb_btn_step_conditioner.sv - randomized and directed self-checking bench for btn_step_conditioner
module tb_btn_step_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    btn_step_conditioner_if bus ();

    btn_step_conditioner #(
        .DB_CYCLES     (DB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference: level flips once the synchronized input has disagreed with it
    // for DB+1 consecutive edges; repeat timing counts edges of stable holding.
    bit h1, h2;
    bit m_lvl, m_rep, m_step;
    int run, cnt;
    bit p_lvl, p_rep;
    int edge_no = 0;
    int base = 0;
    int step_log[$];
    int fall_log[$];
    int rrise_log[$];
    int rfall_log[$];

    function automatic void model_clear();
        h1 = 0; h2 = 0;
        m_lvl = 0; m_rep = 0; m_step = 0;
        run = 0; cnt = 0;
        p_lvl = 0; p_rep = 0;
    endfunction

    function automatic void model_edge(bit raw, bit r);
        bit s;
        s  = h2;
        h2 = h1;
        h1 = raw;
        m_step = 0;
        if (!m_lvl) begin
            run = s ? run + 1 : 0;
            if (run == DB + 1) begin
                m_lvl = 1; m_step = 1; run = 0; cnt = 0; m_rep = 0;
            end
        end else if (!s) begin
            m_rep = 0; cnt = 0; run++;
            if (run == DB + 1) begin
                m_lvl = 0; run = 0;
            end
        end else if (run > 0) begin
            run = 0; cnt = 0;
        end else if (!m_rep) begin
            if (!r) cnt = 0;
            else if (cnt == HOLD - 1) begin m_rep = 1; m_step = 1; cnt = 0; end
            else cnt++;
        end else begin
            if (!r) begin m_rep = 0; cnt = 0; end
            else if (cnt == REP - 1) begin m_step = 1; cnt = 0; end
            else cnt++;
        end
    endfunction

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_no);
        end
    endfunction

    always @(posedge clk) begin
        if (reset_n) begin
            edge_no++;
            model_edge(bus.btn_raw, bus.rpt_en);
            if (m_step) step_log.push_back(edge_no);
            if (!m_lvl && p_lvl) fall_log.push_back(edge_no);
            if (m_rep && !p_rep) rrise_log.push_back(edge_no);
            if (!m_rep && p_rep) rfall_log.push_back(edge_no);
            p_lvl = m_lvl;
            p_rep = m_rep;
            #1;
            check("step", int'(bus.step), int'(m_step));
            check("btn_level", int'(bus.btn_level), int'(m_lvl));
            check("rpt_active", int'(bus.rpt_active), int'(m_rep));
        end
    end

    function automatic int s_at(int i);
        return (i < step_log.size()) ? step_log[i] - base : -1;
    endfunction
    function automatic int fall_at(int i);
        return (i < fall_log.size()) ? fall_log[i] - base : -1;
    endfunction
    function automatic int rrise_at(int i);
        return (i < rrise_log.size()) ? rrise_log[i] - base : -1;
    endfunction
    function automatic int rfall_at(int i);
        return (i < rfall_log.size()) ? rfall_log[i] - base : -1;
    endfunction

    function automatic void clear_logs();
        base = edge_no;
        step_log.delete();
        fall_log.delete();
        rrise_log.delete();
        rfall_log.delete();
    endfunction

    task automatic hold(bit v, int n);
        bus.btn_raw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_step", int'(bus.step), 0);
        check("rst_level", int'(bus.btn_level), 0);
        check("rst_rpt", int'(bus.rpt_active), 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int remain;
        bit val;
        reset_n     = 1'b0;
        bus.btn_raw = 1'b0;
        bus.rpt_en  = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_step", int'(bus.step), 0);
        check("reset_level", int'(bus.btn_level), 0);
        check("reset_rpt", int'(bus.rpt_active), 0);
        reset_n = 1'b1;
        hold(0, 3);

        // single press, no repeat
        clear_logs();
        hold(1, 20);
        hold(0, 15);
        check("t1_nsteps", step_log.size(), 1);
        check("t1_step_edge", s_at(0), 7);
        check("t1_fall_edge", fall_at(0), 27);

        // pulse too short, then just long enough
        clear_logs();
        hold(1, 4);
        hold(0, 15);
        check("t2_short_nsteps", step_log.size(), 0);
        check("t2_short_nfall", fall_log.size(), 0);
        clear_logs();
        hold(1, 5);
        hold(0, 15);
        check("t2_long_nsteps", step_log.size(), 1);
        check("t2_long_step", s_at(0), 7);

        // auto-repeat cadence
        bus.rpt_en = 1'b1;
        clear_logs();
        hold(1, 22);
        check("t3_step0", s_at(0), 7);
        check("t3_step1", s_at(1), 15);
        check("t3_step2", s_at(2), 18);
        check("t3_step3", s_at(3), 21);
        check("t3_rpt_rise", rrise_at(0), 15);
        hold(0, 15);

        // release bounce while held restarts the hold-off
        clear_logs();
        hold(1, 10);
        hold(0, 2);
        hold(1, 20);
        check("t4_step0", s_at(0), 7);
        check("t4_step1", s_at(1), 23);
        check("t4_nfall", fall_log.size(), 0);
        hold(0, 15);

        // reset in the middle of repeating
        hold(1, 20);
        do_reset();
        clear_logs();
        hold(1, 12);
        check("t5_nsteps", step_log.size(), 1);
        check("t5_step0", s_at(0), 7);
        hold(0, 15);

        // dropping rpt_en leaves repeat without a step
        clear_logs();
        hold(1, 20);
        bus.rpt_en = 1'b0;
        hold(1, 10);
        check("t6_nsteps", step_log.size(), 3);
        check("t6_step2", s_at(2), 18);
        check("t6_rpt_fall", rfall_at(0), 21);
        check("t6_nfall", fall_log.size(), 0);
        hold(0, 15);

        // randomized bouncing, repeat toggling and occasional resets
        remain = 0;
        val = 0;
        for (int i = 0; i < 4000; i++) begin
            if (remain == 0) begin
                val = ~val;
                remain = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 7);
            end
            if ($urandom_range(0, 23) == 0) bus.rpt_en = ~bus.rpt_en;
            if ($urandom_range(0, 499) == 0) do_reset();
            hold(val, 1);
            remain--;
        end
        hold(0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
